// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory bus arbiter.
//   state_t     : arbiter FSM states (IDLE, ISSUE, RDWAIT)
//   NREQ        : number of requesters (bit0 = CPU control unit, bit1 = DMA)
//   DATA_W_DEF  : default data word width
//   ADDR_W_DEF  : default memory address width
//   idx_onehot  : requester index -> one-hot grant/ack vector
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int NREQ       = 2;
  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] idx_onehot(input logic idx);
    idx_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the requester side and the RAM side of the arbiter.
//   slave  modport : the arbiter's view
//   master modport : the environment's view (requesters + RAM)
// Signals:
//   req[1:0], we[1:0]        per-requester request level / store enable
//   addr0/addr1, wdata0/1    per-requester operands
//   gnt[1:0], ack[1:0]       one-hot grant, one-cycle completion pulse
//   rdata, busy              shared load result, arbiter not idle
//   mem_addr/wdata/we        RAM command, mem_rdata RAM data (1-cycle latency)
//   state_dbg                current FSM state, for observation only
//
// Handshake: a requester raises req (with we/addr/wdata) and holds it as a
// level. Its operands are captured on the grant edge, so later changes do not
// disturb the transaction. gnt stays high until the cycle in which ack pulses
// for exactly one cycle; the requester drops req on that ack edge. A req still
// high once the arbiter is back in IDLE is treated as a new transaction.
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  state_t            state_dbg;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, ack, rdata, busy, mem_addr, mem_wdata, mem_we, state_dbg
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, ack, rdata, busy, mem_addr, mem_wdata, mem_we, state_dbg
  );

endinterface

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin winner selection.
//   req[1:0]  : active requests
//   last_gnt  : index of the requester granted most recently
//   win[1:0]  : one-hot winner, zero when nobody requests
// On a tie the requester that did not win last time is chosen.
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_gnt ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates a CPU control unit (requester 0) and a DMA/loader (requester 1)
// onto one single-port synchronous RAM.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : requester + RAM signals (see mem_bus_arbiter_if)
// Flow: IDLE picks a winner and latches its operands; ISSUE drives the RAM
// for one cycle (stores ack here); RDWAIT captures the RAM data and acks.
// Store latency is 2 cycles from the request being seen, load latency 3.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  // Index of the most recent grant; while busy it is also the current owner.
  logic              last_gnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] rdata_q;
  logic [NREQ-1:0]   win;
  logic              win_idx;
  logic              grant;

  rr_pick2 u_pick (
    .req      (bus.req),
    .last_gnt (last_gnt),
    .win      (win)
  );

  assign win_idx = win[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    bus.gnt    = '0;
    bus.ack    = '0;
    bus.mem_we = 1'b0;
    case (state)
      IDLE: begin
        if (|win) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.gnt    = idx_onehot(last_gnt);
        bus.mem_we = lat_we;
        if (lat_we) begin
          bus.ack   = idx_onehot(last_gnt);
          state_nxt = IDLE;
        end else begin
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        bus.gnt   = idx_onehot(last_gnt);
        bus.ack   = idx_onehot(last_gnt);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_gnt resets to the DMA index so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (grant) begin
        last_gnt  <= win_idx;
        lat_addr  <= win_idx ? bus.addr1  : bus.addr0;
        lat_wdata <= win_idx ? bus.wdata1 : bus.wdata0;
        lat_we    <= bus.we[win_idx];
      end
      // RAM data for the address issued last cycle is valid during RDWAIT.
      if (state == RDWAIT) rdata_q <= bus.mem_rdata;
    end
  end

  // The RAM address/data hold the latched operands; only mem_we is gated.
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 9;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM environment (synchronous, 1-cycle read) ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)          ram[pre_addr]     <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int            total = 0;
  int            bad = 0;
  int            last_win = 1;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rdata = '0;
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 9'h0A3;
    if (i == 7) return 9'h077;
    return DW'((i * 37 + 11) % 512);
  endfunction

  // Round-robin rule: a lone requester wins; on a tie, whoever did not go last.
  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b11) return (last_win == 0) ? 1 : 0;
    if (r == 2'b10) return 1;
    return 0;
  endfunction

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((bus.gnt & 2'(bus.gnt - 2'd1)) != 2'b00 || (bus.ack & ~bus.gnt) != 2'b00 ||
          (bus.mem_we && bus.state_dbg != ISSUE)) begin
        bad++;
        $display("FAIL invariant gnt=%b ack=%b mem_we=%b state=%0d", bus.gnt, bus.ack, bus.mem_we, bus.state_dbg);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req = r; bus.we = w; bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_win = 1;
    exp_rdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", bus.ack); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 9'h000) begin bad++; $display("FAIL reset_mem_addr got=%h exp=000", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 9'h000) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=000", bus.mem_wdata); end
    total++; if (bus.rdata !== 9'h000) begin bad++; $display("FAIL reset_rdata got=%h exp=000", bus.rdata); end
    @(posedge clk); #1 rst = 1'b0;
    last_win = 1;
  endtask

  task automatic test_cpu_load();
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 9'h005, 9'h000, 9'h000, 9'h000);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.gnt !== ((c == 1) ? 2'b00 : 2'b01) || bus.ack !== ((c == 3) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL cpu_load_c%0d got gnt=%b ack=%b", c, bus.gnt, bus.ack);
      end
    end
    @(posedge clk); #1 bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.rdata !== 9'h0A3) begin bad++; $display("FAIL cpu_load_rdata got=%h exp=0a3", bus.rdata); end
    last_win = 0; exp_rdata = 9'h0A3;
  endtask

  task automatic test_dma_store();
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 9'h000, 9'h010, 9'h000, 9'h155);
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0 || bus.gnt !== 2'b00) begin bad++; $display("FAIL dma_c1 got mem_we=%b gnt=%b", bus.mem_we, bus.gnt); end
    @(negedge clk);
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 9'h010 || bus.mem_wdata !== 9'h155 || bus.ack !== 2'b10 || bus.gnt !== 2'b10) begin
      bad++; $display("FAIL dma_c2 got mem_we=%b addr=%h wdata=%h ack=%b gnt=%b", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ack, bus.gnt);
    end
    @(posedge clk); #1 bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0 || bus.ack !== 2'b00) begin bad++; $display("FAIL dma_c3 got mem_we=%b ack=%b", bus.mem_we, bus.ack); end
    total++; if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL dma_rdata_held got=%h exp=%h", bus.rdata, exp_rdata); end
    total++; if (ram[16] !== 9'h155) begin bad++; $display("FAIL dma_ram got=%h exp=155", ram[16]); end
    ref_mem[16] = 9'h155; last_win = 1;
  endtask

  task automatic test_latch();
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 9'h005, 9'h000, 9'h000, 9'h000);
    @(negedge clk);
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 9'h007, 9'h000, 9'h1AA, 9'h000);
    @(negedge clk);
    total++; if (bus.mem_addr !== 9'h005 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL latch_issue got addr=%h mem_we=%b exp 005/0", bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL latch_ack got=%b exp=01", bus.ack); end
    @(posedge clk); #1 bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.rdata !== 9'h0A3) begin bad++; $display("FAIL latch_rdata got=%h exp=0a3", bus.rdata); end
    last_win = 0; exp_rdata = 9'h0A3;
  endtask

  task automatic test_alternate();
    int k;
    logic [1:0] exp_oh;
    do_reset();
    @(posedge clk); #1;
    drive(2'b11, 2'b00, 9'h005, 9'h010, 9'h000, 9'h000);
    k = 0;
    for (int c = 1; c <= 20 && k < 4; c++) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) begin
        exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (bus.ack !== exp_oh || c != 3 * (k + 1)) begin
          bad++; $display("FAIL alt_%0d got ack=%b cycle=%0d exp ack=%b cycle=%0d", k, bus.ack, c, exp_oh, 3 * (k + 1));
        end
        k++;
      end
    end
    total++; if (k != 4) begin bad++; $display("FAIL alt_timeout got acks=%0d exp=4", k); end
    @(posedge clk); #1 bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.rdata !== 9'h155) begin bad++; $display("FAIL alt_rdata got=%h exp=155", bus.rdata); end
    last_win = 1; exp_rdata = 9'h155;
  endtask

  task automatic test_reset_mid();
    int lat;
    // Load aborted while waiting for RAM data.
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 9'h005, 9'h010, 9'h000, 9'h000);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    bus.req = 2'b11;
    #1;
    total++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
      bad++; $display("FAIL rstmid_async got gnt=%b busy=%b ack=%b", bus.gnt, bus.busy, bus.ack);
    end
    @(negedge clk);
    total++; if (bus.ack !== 2'b00 || bus.rdata !== 9'h000) begin bad++; $display("FAIL rstmid_hold got ack=%b rdata=%h", bus.ack, bus.rdata); end
    @(posedge clk); #1 rst = 1'b0;
    last_win = 1;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) lat = c;
    end
    total++; if (lat != 3 || bus.ack !== 2'b01) begin bad++; $display("FAIL rstmid_cpu_first got ack=%b lat=%0d exp 01/3", bus.ack, lat); end
    @(posedge clk); #1 bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.rdata !== 9'h0A3) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0a3", bus.rdata); end
    last_win = 0;
    // Store aborted in its write cycle: strobe must drop at once, RAM untouched.
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 9'h000, 9'h020, 9'h000, ~ref_mem[32]);
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rstmid_store_we got=%b exp=1", bus.mem_we); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.mem_we !== 1'b0 || bus.ack !== 2'b00) begin bad++; $display("FAIL rstmid_we_drop got mem_we=%b ack=%b", bus.mem_we, bus.ack); end
    @(posedge clk); #1;
    bus.req = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    total++; if (ram[32] !== ref_mem[32]) begin bad++; $display("FAIL rstmid_ram got=%h exp=%h", ram[32], ref_mem[32]); end
    last_win = 1; exp_rdata = '0;
  endtask

  task automatic test_random(input int n);
    logic [1:0]    r, w, exp_oh;
    logic [AW-1:0] a0, a1, ea;
    logic [DW-1:0] d0, d1, ed;
    int            win, lat, exp_lat;
    for (int t = 0; t < n; t++) begin
      r  = 2'($urandom_range(1, 3));
      w  = 2'($urandom_range(0, 3));
      a0 = (t % 7 == 0) ? 9'h1FF : AW'($urandom_range(0, 511));
      a1 = (t % 5 == 0) ? 9'h000 : AW'($urandom_range(0, 511));
      d0 = DW'($urandom_range(0, 511));
      d1 = DW'($urandom_range(0, 511));
      win = model_pick(r);
      exp_oh = (win == 1) ? 2'b10 : 2'b01;
      ea = (win == 1) ? a1 : a0;
      ed = (win == 1) ? d1 : d0;
      exp_lat = w[win] ? 2 : 3;
      if (!w[win]) exp_q.push_back(ref_mem[ea]);
      @(posedge clk); #1;
      drive(r, w, a0, a1, d0, d1);
      lat = 0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
        @(negedge clk);
        total++;
        if (bus.gnt !== ((c == 1) ? 2'b00 : exp_oh)) begin
          bad++; $display("FAIL rand_gnt t=%0d c=%0d got=%b exp=%b", t, c, bus.gnt, (c == 1) ? 2'b00 : exp_oh);
        end
        if (c == 2) begin
          total++;
          if (bus.mem_addr !== ea || bus.mem_we !== w[win] || (w[win] && bus.mem_wdata !== ed)) begin
            bad++; $display("FAIL rand_issue t=%0d got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                            t, bus.mem_addr, bus.mem_we, bus.mem_wdata, ea, w[win], ed);
          end
        end
        if (bus.ack !== 2'b00) lat = c;
        if (c == 1) begin
          // Operands change after the grant; the transaction must not see it.
          @(posedge clk); #1;
          drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 511)),
                AW'($urandom_range(0, 511)), DW'($urandom_range(0, 511)), DW'($urandom_range(0, 511)));
        end
      end
      total++;
      if (lat != exp_lat || bus.ack !== exp_oh) begin
        bad++; $display("FAIL rand_ack t=%0d got ack=%b lat=%0d exp ack=%b lat=%0d", t, bus.ack, lat, exp_oh, exp_lat);
      end
      if (w[win]) ref_mem[ea] = ed;
      else        exp_rdata = exp_q.pop_front();
      last_win = win;
      @(posedge clk); #1;
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      @(negedge clk);
      total++;
      if (bus.rdata !== exp_rdata) begin bad++; $display("FAIL rand_rdata t=%0d got=%h exp=%h", t, bus.rdata, exp_rdata); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    rst = 1'b1;
    pre_we = 1'b1;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = init_val(i);
      pre_addr = AW'(i);
      pre_data = ref_mem[i];
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    test_reset();
    test_cpu_load();
    test_dma_store();
    test_latch();
    test_alternate();
    test_reset_mid();
    test_random(60);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
